// File: rtl/fifo_to_uart_ser.sv
// -----------------------------------------------------------------------------
// fifo_to_uart_ser
//
// Pops one multi-byte word from the TX FIFO, latches it, then hands it to the
// UART transmitter one byte at a time using a start/done handshake. The byte
// order is fixed at elaboration by MSB_FIRST. All logic runs on one clock.
//
// Parameters
//   N_BYTES    bytes per FIFO word (>= 2)
//   BYTE_W     bits per byte sent to the transmitter
//   MSB_FIRST  0: byte 0 (din[BYTE_W-1:0]) goes first; 1: top byte goes first
//
// Ports
//   clk         in   system clock, rising edge
//   sys_rst_l   in   asynchronous active-low reset
//   en          in   1: allow new FIFO pops; 0: finish current word, then hold
//   fifo_empty  in   TX FIFO empty flag
//   fifo_rd_en  out  one-cycle FIFO pop strobe
//   din         in   FIFO read data, valid the cycle after fifo_rd_en
//   tx_data     out  byte presented to the transmitter
//   tx_start    out  one-cycle start strobe to the transmitter
//   tx_done     in   one-cycle pulse: transmitter finished the current byte
//   busy        out  1 whenever the FSM is not idle
//   byte_idx    out  send-order index of the byte in flight
//   word_done   out  one-cycle pulse after the last byte is acknowledged
//
// All outputs are registered or decoded from registered state only.
// -----------------------------------------------------------------------------
module fifo_to_uart_ser #(
    parameter int N_BYTES   = 8,
    parameter int BYTE_W    = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                         clk,
    input  logic                         sys_rst_l,
    input  logic                         en,
    input  logic                         fifo_empty,
    output logic                         fifo_rd_en,
    input  logic [N_BYTES*BYTE_W-1:0]    din,
    output logic [BYTE_W-1:0]            tx_data,
    output logic                         tx_start,
    input  logic                         tx_done,
    output logic                         busy,
    output logic [$clog2(N_BYTES)-1:0]   byte_idx,
    output logic                         word_done
);

    localparam int WORD_W = N_BYTES * BYTE_W;
    localparam int IDX_W  = $clog2(N_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LAT,
        SEND,
        WAIT
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  idx_next;

    // Send-order index to byte lane. With MSB_FIRST the lane is mirrored so
    // index 0 always means "first byte on the wire".
    function automatic logic [BYTE_W-1:0] pick_byte(
        input logic [WORD_W-1:0] w,
        input logic [IDX_W-1:0]  idx
    );
        int slot;
        slot = MSB_FIRST ? (N_BYTES - 1 - int'(idx)) : int'(idx);
        return BYTE_W'(w >> (slot * BYTE_W));
    endfunction

    assign idx_next = byte_idx + IDX_W'(1);
    assign busy     = (state != IDLE);

    // NOTE: every register below is assigned with <= so all of them update
    // together from the values sampled at the same edge.
    always_ff @(posedge clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state      <= IDLE;
            fifo_rd_en <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            byte_idx   <= '0;
            word_done  <= 1'b0;
            // NOTE: the word register is a plain flop bank, not a RAM, so it
            // is cleared on reset; a word in flight is simply dropped.
            word_q     <= '0;
        end else begin
            // Strobes are one-cycle pulses: low unless a state below raises them.
            fifo_rd_en <= 1'b0;
            tx_start   <= 1'b0;
            word_done  <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (en && !fifo_empty) begin
                        fifo_rd_en <= 1'b1;
                        state      <= RD;
                    end
                end

                // Pop strobe is high during this cycle; data arrives next cycle.
                RD: state <= LAT;

                // din is valid now. The first byte is taken straight from din
                // so tx_data is ready in the same cycle tx_start rises.
                LAT: begin
                    word_q   <= din;
                    byte_idx <= '0;
                    tx_data  <= pick_byte(din, IDX_W'(0));
                    tx_start <= 1'b1;
                    state    <= SEND;
                end

                SEND: state <= WAIT;

                // tx_data holds its value until the transmitter acknowledges.
                WAIT: begin
                    if (tx_done) begin
                        if (byte_idx == LAST_IDX) begin
                            byte_idx  <= '0;
                            word_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            byte_idx <= idx_next;
                            tx_data  <= pick_byte(word_q, idx_next);
                            tx_start <= 1'b1;
                            state    <= SEND;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_to_uart_ser.sv
// -----------------------------------------------------------------------------
// tb_fifo_to_uart_ser
//
// Two instances share every input: dut_l sends byte 0 first, dut_m sends the
// top byte first. A negedge monitor logs pops, start strobes (data + index)
// and word_done pulses, and acts as the transmitter by answering each
// tx_start with a tx_done pulse DONE_GAP cycles later. The main thread drives
// stimulus and compares against hand-written byte sequences.
// -----------------------------------------------------------------------------
module tb_fifo_to_uart_ser;

    localparam int N_BYTES  = 8;
    localparam int BYTE_W   = 8;
    localparam int IDX_W    = 3;
    localparam int DW       = N_BYTES * BYTE_W;
    localparam int DONE_GAP = 10;

    logic          clk        = 1'b0;
    logic          sys_rst_l  = 1'b0;
    logic          en         = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] din        = '0;
    logic          spur_done  = 1'b0;
    logic          auto_done  = 1'b0;
    logic          tx_done;

    logic              fifo_rd_en_l, tx_start_l, busy_l, word_done_l;
    logic [BYTE_W-1:0] tx_data_l;
    logic [IDX_W-1:0]  byte_idx_l;
    logic              fifo_rd_en_m, tx_start_m, busy_m, word_done_m;
    logic [BYTE_W-1:0] tx_data_m;
    logic [IDX_W-1:0]  byte_idx_m;

    assign tx_done = auto_done | spur_done;

    always #5 clk = ~clk;

    fifo_to_uart_ser #(.N_BYTES(N_BYTES), .BYTE_W(BYTE_W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .sys_rst_l(sys_rst_l), .en(en), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en_l), .din(din), .tx_data(tx_data_l),
        .tx_start(tx_start_l), .tx_done(tx_done), .busy(busy_l),
        .byte_idx(byte_idx_l), .word_done(word_done_l)
    );

    fifo_to_uart_ser #(.N_BYTES(N_BYTES), .BYTE_W(BYTE_W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .sys_rst_l(sys_rst_l), .en(en), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en_m), .din(din), .tx_data(tx_data_m),
        .tx_start(tx_start_m), .tx_done(tx_done), .busy(busy_m),
        .byte_idx(byte_idx_m), .word_done(word_done_m)
    );

    // Hand-computed expected byte sequences.
    localparam logic [DW-1:0] W0 = 64'h8877665544332211;
    localparam logic [DW-1:0] WA = 64'hF0E0D0C0B0A09080;
    localparam logic [DW-1:0] WB = 64'h0F1E2D3C4B5A6978;
    localparam logic [DW-1:0] WC = 64'h1122334455667788;
    localparam logic [DW-1:0] WD = 64'hCAFEBABEDEADBEEF;

    logic [7:0] exp_w0_l [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] exp_w0_m [8] = '{8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    logic [7:0] exp_wa_l [8] = '{8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0};
    logic [7:0] exp_wb_l [8] = '{8'h78, 8'h69, 8'h5A, 8'h4B, 8'h3C, 8'h2D, 8'h1E, 8'h0F};
    logic [7:0] exp_wd_l [8] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hBE, 8'hBA, 8'hFE, 8'hCA};
    logic [7:0] exp_wd_m [8] = '{8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- monitor + transmitter model ----------------
    int cyc       = 0;
    int rd_cnt    = 0;
    int rd_cyc    = 0;
    int wd_cnt    = 0;
    int rsp_cnt   = 0;
    logic [7:0]       q_l [$];
    logic [7:0]       q_m [$];
    logic [IDX_W-1:0] q_idx_l [$];
    logic [IDX_W-1:0] q_idx_m [$];
    int               start_cyc_q [$];
    int               done_cyc_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_rd_en_l) begin
            rd_cnt <= rd_cnt + 1;
            rd_cyc <= cyc;
        end
        if (tx_start_l) begin
            q_l.push_back(tx_data_l);
            q_idx_l.push_back(byte_idx_l);
            start_cyc_q.push_back(cyc);
        end
        if (tx_start_m) begin
            q_m.push_back(tx_data_m);
            q_idx_m.push_back(byte_idx_m);
        end
        if (word_done_l) wd_cnt <= wd_cnt + 1;

        if (!sys_rst_l) begin
            rsp_cnt   <= 0;
            auto_done <= 1'b0;
        end else if (tx_start_l) begin
            rsp_cnt   <= DONE_GAP;
            auto_done <= 1'b0;
        end else if (rsp_cnt == 1) begin
            rsp_cnt   <= 0;
            auto_done <= 1'b1;
            done_cyc_q.push_back(cyc);
        end else begin
            if (rsp_cnt > 1) rsp_cnt <= rsp_cnt - 1;
            auto_done <= 1'b0;
        end
    end

    // ---------------- helpers (stimulus / waiting only) ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rd(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (fifo_rd_en_l) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_wd(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (word_done_l) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sys_rst_l  = 1'b0;
        en         = 1'b1;
        fifo_empty = 1'b0;
        din        = W0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({fifo_rd_en_l, tx_start_l, busy_l, fifo_rd_en_m, tx_start_m, busy_m} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_strobes cycle %0d: got rd/start/busy l=%b%b%b m=%b%b%b, want all 0",
                         i, fifo_rd_en_l, tx_start_l, busy_l, fifo_rd_en_m, tx_start_m, busy_m);
            end
        end
        n_checks++;
        if ({tx_data_l, byte_idx_l, word_done_l, tx_data_m, byte_idx_m, word_done_m} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h/%h idx=%0d/%0d wd=%b/%b, want all 0",
                     tx_data_l, tx_data_m, byte_idx_l, byte_idx_m, word_done_l, word_done_m);
        end
        fifo_empty = 1'b1;
        tick();
        sys_rst_l = 1'b1;
        tick();
        tick();
        n_checks++;
        if (busy_l !== 1'b0 || rd_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got busy=%b pops=%0d, want busy=0 pops=0", busy_l, rd_cnt);
        end
    endtask

    // One word with both byte orders; the two instances see identical stimulus.
    task automatic test_single_word();
        int rd0, wd0, sb;
        bit ok;
        rd0 = rd_cnt;
        wd0 = wd_cnt;
        sb  = q_l.size();
        din = W0;
        en  = 1'b1;
        fifo_empty = 1'b0;
        wait_rd(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_pop_timeout: got no fifo_rd_en, want one within 20 cycles");
        end
        fifo_empty = 1'b1;
        wait_wd(300, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_word_done_timeout: got no word_done, want one within 300 cycles");
        end
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (rd_cnt - rd0 != 1 || wd_cnt - wd0 != 1 || q_l.size() - sb != 8) begin
            n_fail++;
            $display("FAIL single_counts: got pops=%0d word_done=%0d starts=%0d, want 1/1/8",
                     rd_cnt - rd0, wd_cnt - wd0, q_l.size() - sb);
        end
        for (int i = 0; i < 8; i++) begin
            if (sb + i < q_l.size()) begin
                n_checks++;
                if (q_l[sb+i] !== exp_w0_l[i] || q_idx_l[sb+i] !== IDX_W'(i)) begin
                    n_fail++;
                    $display("FAIL lsb_first_byte%0d: got data=%h idx=%0d, want data=%h idx=%0d",
                             i, q_l[sb+i], q_idx_l[sb+i], exp_w0_l[i], i);
                end
            end
        end
        n_checks++;
        if (busy_l !== 1'b0 || byte_idx_l !== '0) begin
            n_fail++;
            $display("FAIL single_end_idle: got busy=%b idx=%0d, want 0/0", busy_l, byte_idx_l);
        end
    endtask

    task automatic test_msb_first();
        int sb;
        bit ok;
        sb  = q_m.size();
        din = W0;
        en  = 1'b1;
        fifo_empty = 1'b0;
        wait_rd(20, ok);
        fifo_empty = 1'b1;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL msb_pop_timeout: got no fifo_rd_en, want one within 20 cycles");
        end
        wait_wd(300, ok);
        n_checks++;
        if (!ok || q_m.size() - sb != 8) begin
            n_fail++;
            $display("FAIL msb_word: got done=%b starts=%0d, want done=1 starts=8", ok, q_m.size() - sb);
        end
        for (int i = 0; i < 8; i++) begin
            if (sb + i < q_m.size()) begin
                n_checks++;
                if (q_m[sb+i] !== exp_w0_m[i] || q_idx_m[sb+i] !== IDX_W'(i)) begin
                    n_fail++;
                    $display("FAIL msb_first_byte%0d: got data=%h idx=%0d, want data=%h idx=%0d",
                             i, q_m[sb+i], q_idx_m[sb+i], exp_w0_m[i], i);
                end
            end
        end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_latency();
        int c0, sb, db;
        bit ok;
        sb  = start_cyc_q.size();
        db  = done_cyc_q.size();
        din = WA;
        en  = 1'b1;
        tick();
        c0 = cyc;
        fifo_empty = 1'b0;
        wait_rd(20, ok);
        fifo_empty = 1'b1;
        n_checks++;
        if (!ok || rd_cyc - c0 != 1) begin
            n_fail++;
            $display("FAIL latency_pop: got pop at +%0d (seen=%b), want +1", rd_cyc - c0, ok);
        end
        wait_wd(300, ok);
        n_checks++;
        if (!ok || start_cyc_q.size() - sb != 8 || done_cyc_q.size() - db != 8) begin
            n_fail++;
            $display("FAIL latency_word: got done=%b starts=%0d acks=%0d, want 1/8/8",
                     ok, start_cyc_q.size() - sb, done_cyc_q.size() - db);
        end else begin
            n_checks++;
            if (start_cyc_q[sb] - c0 != 3) begin
                n_fail++;
                $display("FAIL latency_first_start: got +%0d, want +3", start_cyc_q[sb] - c0);
            end
            for (int j = 1; j < 8; j++) begin
                n_checks++;
                if (start_cyc_q[sb+j] - done_cyc_q[db+j-1] != 1) begin
                    n_fail++;
                    $display("FAIL latency_done_to_start%0d: got %0d cycles, want 1",
                             j, start_cyc_q[sb+j] - done_cyc_q[db+j-1]);
                end
            end
        end
        for (int i = 0; i < 4; i++) tick();
    endtask

    // Two words queued; en dropped during word 1; spurious tx_done in
    // IDLE, RD, LAT and SEND.
    task automatic test_en_toggle();
        int rd0, wd0, sb;
        bit ok, stray;
        rd0 = rd_cnt;
        wd0 = wd_cnt;
        sb  = q_l.size();
        din = WA;
        en  = 1'b1;
        fifo_empty = 1'b0;
        wait_rd(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL en_first_pop_timeout: got no fifo_rd_en, want one within 20 cycles");
        end
        tick();
        tick();
        din = WB;
        en  = 1'b0;
        wait_wd(300, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL en_word1_done_timeout: got no word_done, want word 1 to complete");
        end
        stray = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (fifo_rd_en_l || busy_l) stray = 1'b1;
        end
        n_checks++;
        if (stray || rd_cnt - rd0 != 1) begin
            n_fail++;
            $display("FAIL en_low_hold: got pops=%0d activity=%b, want pops=1 activity=0", rd_cnt - rd0, stray);
        end
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        tick();
        n_checks++;
        if (busy_l !== 1'b0 || byte_idx_l !== '0 || tx_start_l !== 1'b0 || word_done_l !== 1'b0) begin
            n_fail++;
            $display("FAIL spur_done_idle: got busy=%b idx=%0d start=%b wd=%b, want 0/0/0/0",
                     busy_l, byte_idx_l, tx_start_l, word_done_l);
        end
        en = 1'b1;
        wait_rd(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL en_second_pop_timeout: got no fifo_rd_en after en=1, want one");
        end
        spur_done = 1'b1;
        tick();
        tick();
        fifo_empty = 1'b1;
        n_checks++;
        if (tx_start_l !== 1'b1 || byte_idx_l !== '0) begin
            n_fail++;
            $display("FAIL spur_done_lat: got start=%b idx=%0d, want start=1 idx=0", tx_start_l, byte_idx_l);
        end
        tick();
        spur_done = 1'b0;
        wait_wd(300, ok);
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (!ok || rd_cnt - rd0 != 2 || wd_cnt - wd0 != 2 || q_l.size() - sb != 16) begin
            n_fail++;
            $display("FAIL en_counts: got done=%b pops=%0d word_done=%0d starts=%0d, want 1/2/2/16",
                     ok, rd_cnt - rd0, wd_cnt - wd0, q_l.size() - sb);
        end
        for (int i = 0; i < 16; i++) begin
            if (sb + i < q_l.size()) begin
                n_checks++;
                if (q_l[sb+i] !== (i < 8 ? exp_wa_l[i%8] : exp_wb_l[i%8])) begin
                    n_fail++;
                    $display("FAIL two_words_byte%0d: got %h, want %h",
                             i, q_l[sb+i], (i < 8 ? exp_wa_l[i%8] : exp_wb_l[i%8]));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int wd0, sb, sbm;
        bit ok;
        wd0 = wd_cnt;
        din = WC;
        en  = 1'b1;
        fifo_empty = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (busy_l && !tx_start_l && byte_idx_l == IDX_W'(4)) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL async_reach_wait4: got no WAIT at byte_idx=4, want it within 300 cycles");
        end
        din = WD;
        sys_rst_l = 1'b0;
        #1;
        n_checks++;
        if ({fifo_rd_en_l, tx_start_l, busy_l, word_done_l, tx_data_l, byte_idx_l} !== '0 ||
            {fifo_rd_en_m, tx_start_m, busy_m, word_done_m, tx_data_m, byte_idx_m} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_clear: got busy=%b data=%h idx=%0d start=%b, want all 0 without clock",
                     busy_l, tx_data_l, byte_idx_l, tx_start_l);
        end
        for (int i = 0; i < 3; i++) tick();
        sb  = q_l.size();
        sbm = q_m.size();
        sys_rst_l = 1'b1;
        wait_rd(20, ok);
        fifo_empty = 1'b1;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL async_repop_timeout: got no fifo_rd_en after release, want one");
        end
        wait_wd(300, ok);
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (!ok || wd_cnt - wd0 != 1 || q_l.size() - sb != 8 || q_m.size() - sbm != 8) begin
            n_fail++;
            $display("FAIL async_fresh_word: got done=%b word_done=%0d starts=%0d/%0d, want 1/1/8/8",
                     ok, wd_cnt - wd0, q_l.size() - sb, q_m.size() - sbm);
        end
        for (int i = 0; i < 8; i++) begin
            if (sb + i < q_l.size() && sbm + i < q_m.size()) begin
                n_checks++;
                if (q_l[sb+i] !== exp_wd_l[i] || q_idx_l[sb+i] !== IDX_W'(i) || q_m[sbm+i] !== exp_wd_m[i]) begin
                    n_fail++;
                    $display("FAIL async_fresh_byte%0d: got l=%h idx=%0d m=%h, want l=%h idx=%0d m=%h",
                             i, q_l[sb+i], q_idx_l[sb+i], q_m[sbm+i], exp_wd_l[i], i, exp_wd_m[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_msb_first();
        test_latency();
        test_en_toggle();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test by 500000 ns, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
